lsu_ctrl_mo: RTL

Multi-outstanding load/store control unit between the AGU and the DTCM, successor to the single-outstanding LSU control. It tracks up to `DEPTH` in-flight DTCM accesses in an in-order tracking FIFO. It forms byte-lane write data and masks from access size and address, and aligns and sign/zero-extends load data. It returns load results to the long-pipe write-back and store/error completions to the AGU. Misaligned accesses are flagged without touching the DTCM.

---
 rtl/lsu_ctrl_mo_pkg.sv | 48 ++++
 rtl/lsu_outs_fifo.sv | 70 +++++++
 rtl/lsu_ctrl_mo.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_mo_pkg.sv
// Shared types and helpers for the multi-outstanding LSU control: access-size
// encoding, misalignment rule, byte-lane mask and load-data extraction.
package lsu_ctrl_mo_pkg;

   localparam int XLEN          = 32;
   localparam int NLANES        = XLEN / 8;
   // Tracking entry minus the tag: read, usign, size[1:0], off[1:0], err
   localparam int ENTRY_FIXED_W = 7;

   typedef enum logic [1:0] {
      LSU_SIZE_B = 2'b00,
      LSU_SIZE_H = 2'b01,
      LSU_SIZE_W = 2'b10,
      LSU_SIZE_X = 2'b11
   } lsu_size_e;

   function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
      return (size == LSU_SIZE_X) ||
             (size == LSU_SIZE_H && off[0]) ||
             (size == LSU_SIZE_W && off != 2'b00);
   endfunction

   function automatic logic [NLANES-1:0] lane_mask(input lsu_size_e size, input logic [1:0] off);
      logic [NLANES-1:0] m;
      case (size)
         LSU_SIZE_B: m = 4'b0001 << off;
         LSU_SIZE_H: m = 4'b0011 << off;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input lsu_size_e       size,
                                                     input logic [1:0]      off,
                                                     input logic            usign);
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] v;
      r = rdata >> {off, 3'b000};
      case (size)
         LSU_SIZE_B: v = {{24{~usign & r[7]}},  r[7:0]};
         LSU_SIZE_H: v = {{16{~usign & r[15]}}, r[15:0]};
         default:    v = r;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/lsu_outs_fifo.sv
// Generic DW x DEPTH synchronous FIFO with occupancy count, full and empty.
// Push is ignored when full and pop when empty; no push-on-pop bypass.
module lsu_outs_fifo #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [DW-1:0]    din_i,
   input  logic             pop_i,
   output logic [DW-1:0]    dout_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; a slot is only read while the count says it holds a live entry.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/lsu_ctrl_mo.sv
// Multi-outstanding LSU control: combinational AGU->DTCM command path, in-order
// tracking FIFO, and head-of-FIFO retirement to the AGU or the long-pipe write-back.
module lsu_ctrl_mo
   import lsu_ctrl_mo_pkg::*;
#(
   parameter int AW     = 16,
   parameter int ITAG_W = 1,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              agu_cmd_valid,
   output logic              agu_cmd_ready,
   input  logic              agu_cmd_read,
   input  logic [AW-1:0]     agu_cmd_addr,
   input  logic [XLEN-1:0]   agu_cmd_wdata,
   input  logic [1:0]        agu_cmd_size,
   input  logic              agu_cmd_usign,
   input  logic [ITAG_W-1:0] agu_cmd_itag,

   output logic              agu_rsp_valid,
   input  logic              agu_rsp_ready,
   output logic              agu_rsp_err,
   output logic [ITAG_W-1:0] agu_rsp_itag,

   output logic              dtcm_cmd_valid,
   input  logic              dtcm_cmd_ready,
   output logic              dtcm_cmd_read,
   output logic [AW-1:0]     dtcm_cmd_addr,
   output logic [XLEN-1:0]   dtcm_cmd_wdata,
   output logic [NLANES-1:0] dtcm_cmd_wmask,

   input  logic              dtcm_rsp_valid,
   output logic              dtcm_rsp_ready,
   input  logic [XLEN-1:0]   dtcm_rsp_rdata,

   output logic              lsu_o_valid,
   input  logic              lsu_o_ready,
   output logic [XLEN-1:0]   lsu_o_wbck_wdat,
   output logic [ITAG_W-1:0] lsu_o_wbck_itag
);

   localparam int ENTRY_W = ITAG_W + ENTRY_FIXED_W;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ITAG_W-1:0] itag;
      logic              read;
      logic              usign;
      lsu_size_e         size;
      logic [1:0]        off;
      logic              err;
   } entry_t;

   entry_t           push_entry, head;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   lsu_size_e        cmd_size;
   logic [1:0]       cmd_off;
   logic             cmd_mis;

   assign cmd_size = lsu_size_e'(agu_cmd_size);
   assign cmd_off  = agu_cmd_addr[1:0];
   assign cmd_mis  = is_misaligned(cmd_size, cmd_off);

   // Misaligned commands bypass the DTCM and only need a free tracking slot
   assign agu_cmd_ready  = ~fifo_full & (cmd_mis | dtcm_cmd_ready);
   assign dtcm_cmd_valid = agu_cmd_valid & ~fifo_full & ~cmd_mis;
   assign dtcm_cmd_read  = agu_cmd_read;
   assign dtcm_cmd_addr  = {agu_cmd_addr[AW-1:2], 2'b00};
   assign dtcm_cmd_wdata = agu_cmd_wdata << {cmd_off, 3'b000};
   assign dtcm_cmd_wmask = agu_cmd_read ? '0 : lane_mask(cmd_size, cmd_off);

   assign fifo_push  = agu_cmd_valid & agu_cmd_ready;
   assign push_entry = '{itag:  agu_cmd_itag,
                         read:  agu_cmd_read,
                         usign: agu_cmd_usign,
                         size:  cmd_size,
                         off:   cmd_off,
                         err:   cmd_mis};

   lsu_outs_fifo #(
      .DW    (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_outs_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   (push_entry),
      .pop_i   (fifo_pop),
      .dout_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      agu_rsp_valid  = 1'b0;
      lsu_o_valid    = 1'b0;
      dtcm_rsp_ready = 1'b0;
      fifo_pop       = 1'b0;
      if (!fifo_empty) begin
         if (head.err) begin
            agu_rsp_valid = 1'b1;
            fifo_pop      = agu_rsp_ready;
         end else if (!head.read) begin
            agu_rsp_valid  = dtcm_rsp_valid;
            dtcm_rsp_ready = agu_rsp_ready;
            fifo_pop       = dtcm_rsp_valid & agu_rsp_ready;
         end else begin
            lsu_o_valid    = dtcm_rsp_valid;
            dtcm_rsp_ready = lsu_o_ready;
            fifo_pop       = dtcm_rsp_valid & lsu_o_ready;
         end
      end
   end

   assign agu_rsp_err     = agu_rsp_valid & head.err;
   assign agu_rsp_itag    = agu_rsp_valid ? head.itag : '0;
   assign lsu_o_wbck_itag = lsu_o_valid ? head.itag : '0;
   assign lsu_o_wbck_wdat = lsu_o_valid ? load_extract(dtcm_rsp_rdata, head.size, head.off, head.usign)
                                        : '0;

   a_empty_matches_count: assert property (@(posedge clk) disable iff (rst)
      fifo_empty == (fifo_count == '0));

endmodule
